// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the shared memory/MMIO bus.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface mem_bus_arbiter_if #(
  parameter int unsigned DBITS = 32,
  parameter int unsigned ABITS = 32
);
  logic             cpu_req;
  logic             cpu_we;
  logic [ABITS-1:0] cpu_addr;
  logic [DBITS-1:0] cpu_wdata;
  logic             cpu_gnt;
  logic             cpu_stall;
  logic             cpu_rvalid;
  logic [DBITS-1:0] cpu_rdata;

  logic             aux_req;
  logic             aux_we;
  logic             aux_lock;
  logic [ABITS-1:0] aux_addr;
  logic [DBITS-1:0] aux_wdata;
  logic             aux_gnt;
  logic             aux_rvalid;
  logic [DBITS-1:0] aux_rdata;

  logic             bus_en;
  logic             bus_we;
  logic [ABITS-1:0] bus_addr;
  logic [DBITS-1:0] bus_wdata;
  logic [DBITS-1:0] bus_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  aux_req, aux_we, aux_lock, aux_addr, aux_wdata,
    input  bus_rdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output aux_gnt, aux_rvalid, aux_rdata,
    output bus_en, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output aux_req, aux_we, aux_lock, aux_addr, aux_wdata,
    output bus_rdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  aux_gnt, aux_rvalid, aux_rdata,
    input  bus_en, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the shared data memory / MMIO bus: fixed CPU priority with an aux
// starvation guard, a length-capped aux burst lock, and 1-cycle read-data return routing.
module mem_bus_arbiter #(
  parameter int unsigned DBITS        = 32,
  parameter int unsigned ABITS        = 32,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned LOCK_MAX     = 16,
  parameter int unsigned CNTBITS      = 5
) (
  input logic               clk,
  input logic               reset,
  mem_bus_arbiter_if.slave  bus_if
);

  localparam logic [CNTBITS-1:0] StarveLim = CNTBITS'(STARVE_LIMIT);
  localparam logic [CNTBITS-1:0] LockLim   = CNTBITS'(LOCK_MAX);

  typedef enum logic [0:0] {StNorm, StLock} state_e;

  state_e               state_q, state_d;
  logic [CNTBITS-1:0]   starve_q, starve_d;
  logic [CNTBITS-1:0]   lock_q, lock_d;
  logic                 relock_q, relock_d;
  logic                 cpu_rv_q, aux_rv_q;

  logic                 cpu_gnt, aux_gnt;
  logic                 lock_exit, lock_hold;

  // A locked cycle whose exit condition holds is arbitrated as a normal cycle.
  assign lock_exit = (state_q == StLock) && (!bus_if.aux_lock || (lock_q == LockLim));
  assign lock_hold = (state_q == StLock) && !lock_exit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StNorm;
      starve_q <= '0;
      lock_q   <= '0;
      relock_q <= 1'b0;
      cpu_rv_q <= 1'b0;
      aux_rv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lock_q   <= lock_d;
      relock_q <= relock_d;
      cpu_rv_q <= cpu_gnt && !bus_if.cpu_we;
      aux_rv_q <= aux_gnt && !bus_if.aux_we;
    end
  end

  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    starve_d = '0;
    // Block re-entry after a capped burst until the aux master drops its lock request.
    relock_d = bus_if.aux_lock && (relock_q || ((state_q == StLock) && (lock_q == LockLim)));
    unique case (state_q)
      StNorm: begin
        if (aux_gnt && bus_if.aux_lock && !relock_q) begin
          state_d = StLock;
          lock_d  = CNTBITS'(1);
        end
      end
      StLock: begin
        if (lock_exit) begin
          state_d = StNorm;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      default: state_d = StNorm;
    endcase
    if (!lock_hold && bus_if.aux_req && !aux_gnt) begin
      starve_d = (starve_q == StarveLim) ? starve_q : starve_q + 1'b1;
    end
  end

  always_comb begin
    cpu_gnt = 1'b0;
    aux_gnt = 1'b0;
    if (!reset) begin
      if (lock_hold) begin
        aux_gnt = bus_if.aux_req;
      end else begin
        aux_gnt = bus_if.aux_req && (!bus_if.cpu_req || (starve_q == StarveLim));
        cpu_gnt = bus_if.cpu_req && !aux_gnt;
      end
    end
  end

  assign bus_if.cpu_gnt    = cpu_gnt;
  assign bus_if.aux_gnt    = aux_gnt;
  assign bus_if.cpu_stall  = bus_if.cpu_req && !cpu_gnt;
  assign bus_if.cpu_rvalid = cpu_rv_q;
  assign bus_if.aux_rvalid = aux_rv_q;
  assign bus_if.cpu_rdata  = cpu_rv_q ? bus_if.bus_rdata : {DBITS{1'b0}};
  assign bus_if.aux_rdata  = aux_rv_q ? bus_if.bus_rdata : {DBITS{1'b0}};

  assign bus_if.bus_en    = cpu_gnt || aux_gnt;
  assign bus_if.bus_we    = aux_gnt ? bus_if.aux_we    : (cpu_gnt && bus_if.cpu_we);
  assign bus_if.bus_addr  = aux_gnt ? bus_if.aux_addr  :
                            cpu_gnt ? bus_if.cpu_addr  : {ABITS{1'b0}};
  assign bus_if.bus_wdata = aux_gnt ? bus_if.aux_wdata :
                            cpu_gnt ? bus_if.cpu_wdata : {DBITS{1'b0}};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, multi-cycle corner sequences and random
// traffic, all checked against a cycle-level reference model of the arbitration rules.
module tb_mem_bus_arbiter;
  localparam int unsigned DBITS        = 32;
  localparam int unsigned ABITS        = 32;
  localparam int unsigned STARVE_LIMIT = 8;
  localparam int unsigned LOCK_MAX     = 16;
  localparam int unsigned CNTBITS      = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mem_bus_arbiter_if #(.DBITS(DBITS), .ABITS(ABITS)) bif ();

  mem_bus_arbiter #(
    .DBITS(DBITS), .ABITS(ABITS), .STARVE_LIMIT(STARVE_LIMIT),
    .LOCK_MAX(LOCK_MAX), .CNTBITS(CNTBITS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus_if(bif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: denied-cycle count, burst length so far, burst/blocked flags, pending reads.
  int m_starve, m_len;
  bit m_locked, m_blk, m_cpu_rv, m_aux_rv;

  // DUT outputs captured at the last sample point, for the directed checks.
  bit s_cg, s_ag, s_st, s_crv, s_arv, s_we, s_en;

  typedef struct {
    bit rst, cr, cw, ar, aw, al;
    bit cg, ag, st, crv, arv, we;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle: drive inputs after the edge, compare at the falling edge, advance model.
  task automatic step(input bit r, input bit cr, input bit cw, input bit ar, input bit aw,
                      input bit al);
    logic [ABITS-1:0] ca, aa, ea;
    logic [DBITS-1:0] cd, ad, rd, ed;
    bit in_norm, e_cg, e_ag, enter, was_locked;
    ca = $urandom; aa = $urandom; cd = $urandom; ad = $urandom; rd = $urandom;
    reset = r;
    bif.cpu_req = cr;  bif.cpu_we = cw;  bif.cpu_addr = ca;  bif.cpu_wdata = cd;
    bif.aux_req = ar;  bif.aux_we = aw;  bif.aux_lock = al;  bif.aux_addr = aa;
    bif.aux_wdata = ad; bif.bus_rdata = rd;
    if (r) begin
      m_starve = 0; m_len = 0; m_locked = 0; m_blk = 0; m_cpu_rv = 0; m_aux_rv = 0;
    end
    in_norm = !m_locked || !al || (m_len == LOCK_MAX);
    e_cg = 0;
    e_ag = 0;
    if (!r) begin
      if (in_norm) begin
        e_ag = ar && (!cr || (m_starve == STARVE_LIMIT));
        e_cg = cr && !e_ag;
      end else begin
        e_ag = ar;
      end
    end
    ea = e_ag ? aa : (e_cg ? ca : '0);
    ed = e_ag ? ad : (e_cg ? cd : '0);
    @(negedge clk);
    chk("cpu_gnt",    bif.cpu_gnt,    e_cg);
    chk("aux_gnt",    bif.aux_gnt,    e_ag);
    chk("cpu_stall",  bif.cpu_stall,  cr && !e_cg);
    chk("bus_en",     bif.bus_en,     e_cg || e_ag);
    chk("bus_we",     bif.bus_we,     (e_ag && aw) || (e_cg && cw));
    chk("bus_addr",   bif.bus_addr,   ea);
    chk("bus_wdata",  bif.bus_wdata,  ed);
    chk("cpu_rvalid", bif.cpu_rvalid, m_cpu_rv);
    chk("aux_rvalid", bif.aux_rvalid, m_aux_rv);
    chk("cpu_rdata",  bif.cpu_rdata,  m_cpu_rv ? rd : '0);
    chk("aux_rdata",  bif.aux_rdata,  m_aux_rv ? rd : '0);
    s_cg = bif.cpu_gnt; s_ag = bif.aux_gnt; s_st = bif.cpu_stall; s_en = bif.bus_en;
    s_crv = bif.cpu_rvalid; s_arv = bif.aux_rvalid; s_we = bif.bus_we;
    if (!r) begin
      was_locked = m_locked;
      enter = !m_locked && e_ag && al && !m_blk;
      m_blk = al && (m_blk || (m_locked && (m_len == LOCK_MAX)));
      m_cpu_rv = e_cg && !cw;
      m_aux_rv = e_ag && !aw;
      if (was_locked && !in_norm) begin
        m_starve = 0;
        m_len++;
      end else begin
        if (ar && !e_ag) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
        else m_starve = 0;
        m_locked = enter;
        if (enter) m_len = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt, first, stalls;
    bit al_r;

    //          rst cr cw ar aw al   cg ag st crv arv we
    tbl[0] = '{1, 1, 0, 0, 0, 0,   0, 0, 1, 0,  0,  0};
    tbl[1] = '{0, 1, 0, 0, 0, 0,   1, 0, 0, 0,  0,  0};
    tbl[2] = '{0, 1, 0, 0, 0, 0,   1, 0, 0, 1,  0,  0};
    tbl[3] = '{0, 1, 1, 0, 0, 0,   1, 0, 0, 1,  0,  1};
    tbl[4] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0,  0};
    tbl[5] = '{0, 0, 0, 1, 0, 0,   0, 1, 0, 0,  0,  0};
    tbl[6] = '{0, 1, 0, 1, 1, 0,   1, 0, 0, 0,  1,  0};
    tbl[7] = '{0, 1, 1, 1, 0, 0,   1, 0, 0, 1,  0,  1};
    tbl[8] = '{0, 0, 0, 1, 0, 0,   0, 1, 0, 0,  0,  0};
    tbl[9] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  1,  0};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].cr, tbl[i].cw, tbl[i].ar, tbl[i].aw, tbl[i].al);
      chk($sformatf("tbl%0d_cpu_gnt", i),    s_cg,  tbl[i].cg);
      chk($sformatf("tbl%0d_aux_gnt", i),    s_ag,  tbl[i].ag);
      chk($sformatf("tbl%0d_cpu_stall", i),  s_st,  tbl[i].st);
      chk($sformatf("tbl%0d_cpu_rvalid", i), s_crv, tbl[i].crv);
      chk($sformatf("tbl%0d_aux_rvalid", i), s_arv, tbl[i].arv);
      chk($sformatf("tbl%0d_bus_we", i),     s_we,  tbl[i].we);
    end

    // Continuous contention: aux gets every 9th cycle.
    step(1, 0, 0, 0, 0, 0);
    cnt = 0; first = -1; stalls = 0;
    for (int k = 0; k < 27; k++) begin
      step(0, 1, 0, 1, 0, 0);
      if (s_ag) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (s_st) stalls++;
    end
    chk("contention_aux_count", cnt, 3);
    chk("contention_first_aux", first, 8);
    chk("contention_stalls", stalls, 3);

    // Capped locked burst, then blocked relock until aux_lock drops.
    step(1, 0, 0, 0, 0, 0);
    cnt = 0;
    for (int k = 0; k < 34; k++) begin
      step(0, 1, 0, 1, 1, 1);
      if (k < 24 && s_ag) cnt++;
      if (k == 8)  chk("burst_aux_first", s_ag, 1);
      if (k == 24) chk("burst_cpu_after_cap", s_cg, 1);
      if (k == 32) chk("burst_starve_slot", s_ag, 1);
      if (k == 33) chk("burst_no_relock", s_cg, 1);
    end
    chk("burst_aux_len", cnt, 16);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1);
    step(0, 1, 0, 1, 1, 1);
    chk("relock_after_drop", s_cg, 0);

    // Lock released after three locked writes.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    step(0, 1, 1, 1, 1, 1);
    chk("release_locked_cpu", s_cg, 0);
    step(0, 1, 1, 1, 1, 1);
    chk("release_no_wr_rvalid", s_arv, 0);
    step(0, 1, 1, 1, 0, 0);
    chk("release_cpu_wins", s_cg, 1);
    chk("release_bus_we", s_we, 1);
    chk("release_aux_rvalid", s_arv, 0);

    // Asynchronous reset during a locked aux read.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    step(0, 1, 0, 1, 0, 1);
    step(1, 1, 0, 1, 0, 1);
    chk("rst_aux_rvalid", s_arv, 0);
    chk("rst_bus_en", s_en, 0);
    step(0, 1, 0, 1, 0, 1);
    chk("rst_cpu_first", s_cg, 1);

    // Random traffic with a sticky lock request so bursts of varied length occur.
    step(1, 0, 0, 0, 0, 0);
    al_r = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) al_r = !al_r;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, 1'($urandom),
           $urandom_range(0, 9) < 7, 1'($urandom), al_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single-ported data memory and MMIO bus between two requesters. Port 0 is the pipeline memory stage (CPU). Port 1 is an auxiliary master (debug/loader DMA). The CPU has fixed priority, bounded by a starvation guard for the aux port and a length-capped aux burst lock. The block drives the CPU stall request and routes 1-cycle-latency read data back to the requester that issued the read.

Parameters:
DBITS, 32, data width of bus and both ports
ABITS, 32, address width
STARVE_LIMIT, 8, consecutive denied aux cycles before aux is forced a slot (1..2^CNTBITS-1)
LOCK_MAX, 16, maximum cycles aux may hold the bus in a locked burst (1..2^CNTBITS-1)
CNTBITS, 5, width of the starve and lock counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, level, held until granted
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  ABITS  CPU byte address
cpu_wdata  in  DBITS  CPU write data
cpu_gnt  out  1  CPU access performed this cycle
cpu_stall  out  1  cpu_req && !cpu_gnt
cpu_rvalid  out  1  CPU read data valid (cycle after granted read)
cpu_rdata  out  DBITS  CPU read data
aux_req  in  1  aux access request
aux_we  in  1  aux write / read
aux_lock  in  1  aux requests exclusive burst while high
aux_addr  in  ABITS  aux byte address
aux_wdata  in  DBITS  aux write data
aux_gnt  out  1  aux access performed this cycle
aux_rvalid  out  1  aux read data valid
aux_rdata  out  DBITS  aux read data
bus_en  out  1  shared bus access strobe
bus_we  out  1  shared bus write
bus_addr  out  ABITS  shared bus address
bus_wdata  out  DBITS  shared bus write data
bus_rdata  in  DBITS  shared bus read data, valid 1 cycle after bus_en && !bus_we

Behaviour:
- Grant is combinational from the current-cycle requests plus registered state. At most one of cpu_gnt and aux_gnt is high.
- bus_en = cpu_gnt | aux_gnt. bus_we/addr/wdata are muxed from the winner. When idle: bus_we=0, addr=0, wdata=0.
- States: NORM, LOCK. Reset -> NORM, starve_cnt=0, lock_cnt=0, relock_blk=0, rvalids=0.
- NORM grant rules:
  - aux wins if aux_req && (!cpu_req || starve_cnt==STARVE_LIMIT).
  - Otherwise the CPU wins if cpu_req.
- starve_cnt:
  - +1 when aux_req && !aux_gnt, saturating at STARVE_LIMIT.
  - Cleared when aux_gnt or !aux_req.
- NORM -> LOCK when aux_gnt && aux_lock && !relock_blk. lock_cnt is set to 1.
- LOCK, exit check first:
  - If !aux_lock or lock_cnt==LOCK_MAX, the cycle arbitrates under NORM rules and the next state is NORM.
  - If lock_cnt==LOCK_MAX, relock_blk is set.
- LOCK, otherwise: cpu_gnt=0, aux_gnt=aux_req, lock_cnt+1. starve_cnt is held at 0.
- relock_blk clears on the first cycle with aux_lock=0.
- cpu_stall = cpu_req && !cpu_gnt. This holds in every state, including reset.
- Read return:
  - cpu_rvalid <= cpu_gnt && !cpu_we; aux_rvalid <= aux_gnt && !aux_we. Both registered.
  - cpu_rdata = bus_rdata when cpu_rvalid, else 0. aux_rdata likewise.
  - Writes produce no rvalid.
- Reset asserted mid-burst or mid-read:
  - State returns to NORM; pending rvalids are dropped (0).
  - While reset is high, grants are 0 and bus_en=0.
- Back-to-back: a requester may be granted on consecutive cycles. A read granted in cycle N and another in N+1 give rvalid in N+1 and N+2.

Test Plan:
- CPU only: cpu_req read addr 0x40 cycles 1-3 -> cpu_gnt=1 each cycle, cpu_stall=0, cpu_rvalid in cycles 2-4 carrying bus_rdata.
- Contention: cpu_req and aux_req held continuously, STARVE_LIMIT=8 -> aux_gnt exactly once every 9th cycle, cpu_stall=1 on that cycle only, starve_cnt then restarts from 0.
- Aux idle-slot: cpu_req toggles 1,0,1,0 with aux_req held -> aux granted every cycle cpu_req=0, starve_cnt never exceeds 1.
- Locked burst: aux_lock=1 with aux_req held and cpu_req held, LOCK_MAX=16 -> cpu_gnt=0 for 16 locked cycles, then the CPU is granted. No relock until aux_lock drops for 1 cycle.
- Lock release: aux_lock deasserted after 3 locked writes -> same cycle arbitrated NORM (CPU wins), no aux_rvalid for writes, bus_we follows winner.
- Async reset during LOCK with an aux read pending -> aux_rvalid=0 next cycle, state NORM, cpu_req granted on first cycle after reset release.
